// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, SPECIAL functs, REGIMM rt codes and
// the immediate-extension mode used by the decoder and the next-PC unit.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [4:0] RI_BLTZ = 5'h00;
    localparam logic [4:0] RI_BGEZ = 5'h01;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_LUI  = 2'd2
    } imm_mode_e;

    function automatic imm_mode_e imm_mode_of(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: imm_mode_of = IMM_ZEXT;
            OP_LUI:                   imm_mode_of = IMM_LUI;
            default:                  imm_mode_of = IMM_SEXT;
        endcase
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer: combinational lookup for fetch, one
// synchronous update/invalidate port from decode, saturating direction counters.
module btb_array #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_BITS    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lkp_pc,
    output logic            lkp_taken,
    output logic [XLEN-1:0] lkp_target,
    input  logic            upd_en,
    input  logic            upd_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            inv_en
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
    logic [TAGW-1:0]        tag_d    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    logic [XLEN-1:0]        target_d [BTB_ENTRIES];
    logic [CTR_BITS-1:0]    ctr_q    [BTB_ENTRIES];
    logic [CTR_BITS-1:0]    ctr_d    [BTB_ENTRIES];

    logic [IDX-1:0]  lkp_idx, upd_idx;
    logic [TAGW-1:0] lkp_tag, upd_tag;
    logic            lkp_hit, upd_hit;
    logic            unused_pc_lsbs;

    assign lkp_idx = lkp_pc[IDX+1:2];
    assign lkp_tag = lkp_pc[XLEN-1:IDX+2];
    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX+2];
    assign unused_pc_lsbs = ^{lkp_pc[1:0], upd_pc[1:0]};

    // Lookup reads the registered arrays, so a same-cycle update is not visible.
    assign lkp_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign lkp_taken  = lkp_hit && ctr_q[lkp_idx][CTR_BITS-1];
    assign lkp_target = lkp_hit ? target_q[lkp_idx] : '0;

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (inv_en) begin
            if (upd_hit) begin
                valid_d[upd_idx] = 1'b0;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_ONE;
                    end
                end else if (ctr_q[upd_idx] != CTR_MIN) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_ONE;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = upd_jump ? CTR_MAX : CTR_WEAK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= CTR_ONE;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/next_pc_unit.sv
// Decode-stage control-flow unit: immediate extension, branch/jump target and
// condition resolution, prediction check, BTB training and registered redirect.
module next_pc_unit
    import mips_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_BITS    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    input  logic            valid_d,
    input  logic            stall_d,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [XLEN-1:0] rs_val_d,
    input  logic [XLEN-1:0] rt_val_d,
    input  logic            pred_taken_d,
    input  logic [XLEN-1:0] pred_target_d,
    output logic [XLEN-1:0] imm_ext_d,
    output logic [XLEN-1:0] link_pc_d,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [5:0]      op, funct;
    logic [4:0]      rt_f;
    logic [15:0]     imm;
    logic [XLEN-1:0] br_target, j_target, pc_d;
    logic            rs_neg, rs_zero;
    logic            is_ctrl, is_jump, taken;
    logic [XLEN-1:0] target;
    logic            resolve_en, mispredict;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    assign op    = instr_d[31:26];
    assign rt_f  = instr_d[20:16];
    assign funct = instr_d[5:0];
    assign imm   = instr_d[15:0];

    always_comb begin
        imm_ext_d = {{(XLEN-16){imm[15]}}, imm};
        case (imm_mode_of(op))
            IMM_ZEXT: imm_ext_d = {{(XLEN-16){1'b0}}, imm};
            IMM_LUI:  imm_ext_d = {{(XLEN-32){imm[15]}}, imm, 16'h0000};
            default:  imm_ext_d = {{(XLEN-16){imm[15]}}, imm};
        endcase
    end

    assign link_pc_d = pc_plus4_d + FOUR;
    assign pc_d      = pc_plus4_d - FOUR;
    assign br_target = pc_plus4_d + {{(XLEN-18){imm[15]}}, imm, 2'b00};
    assign j_target  = {pc_plus4_d[XLEN-1:28], instr_d[25:0], 2'b00};
    assign rs_neg    = rs_val_d[XLEN-1];
    assign rs_zero   = (rs_val_d == '0);

    always_comb begin
        is_ctrl = 1'b0;
        is_jump = 1'b0;
        taken   = 1'b0;
        target  = br_target;
        case (op)
            OP_BEQ:  begin is_ctrl = 1'b1; taken = (rs_val_d == rt_val_d); end
            OP_BNE:  begin is_ctrl = 1'b1; taken = (rs_val_d != rt_val_d); end
            OP_BLEZ: begin is_ctrl = 1'b1; taken = rs_neg || rs_zero; end
            OP_BGTZ: begin is_ctrl = 1'b1; taken = !rs_neg && !rs_zero; end
            OP_REGIMM: begin
                if (rt_f == RI_BLTZ) begin
                    is_ctrl = 1'b1;
                    taken   = rs_neg;
                end else if (rt_f == RI_BGEZ) begin
                    is_ctrl = 1'b1;
                    taken   = !rs_neg;
                end
            end
            OP_J, OP_JAL: begin
                is_ctrl = 1'b1;
                is_jump = 1'b1;
                taken   = 1'b1;
                target  = j_target;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    is_ctrl = 1'b1;
                    is_jump = 1'b1;
                    taken   = 1'b1;
                    target  = rs_val_d;
                end
            end
            default: ;
        endcase
    end

    // The instruction sitting in decode while a redirect is out is wrong-path.
    assign resolve_en = valid_d && !stall_d && !redirect_q;
    assign mispredict = is_ctrl ? ((taken != pred_taken_d) ||
                                   (taken && (target != pred_target_d)))
                                : pred_taken_d;

    always_comb begin
        redirect_d    = resolve_en && mispredict;
        redirect_pc_d = redirect_pc_q;
        if (redirect_d) begin
            redirect_pc_d = (is_ctrl && taken) ? target : pc_plus4_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

    btb_array #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .CTR_BITS    (CTR_BITS)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lkp_pc     (pc_f),
        .lkp_taken  (pred_taken_f),
        .lkp_target (pred_target_f),
        .upd_en     (resolve_en && is_ctrl),
        .upd_jump   (is_jump),
        .upd_taken  (taken),
        .upd_pc     (pc_d),
        .upd_target (target),
        .inv_en     (resolve_en && !is_ctrl && pred_taken_d)
    );

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed-vector bench for next_pc_unit with hand-computed expectations.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        valid_d, stall_d;
    logic [31:0] instr_d, pc_plus4_d, rs_val_d, rt_val_d;
    logic        pred_taken_d;
    logic [31:0] pred_target_d;
    logic [31:0] imm_ext_d, link_pc_d;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    next_pc_unit #(.XLEN(32), .BTB_ENTRIES(16), .CTR_BITS(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_f          (pc_f),
        .pred_taken_f  (pred_taken_f),
        .pred_target_f (pred_target_f),
        .valid_d       (valid_d),
        .stall_d       (stall_d),
        .instr_d       (instr_d),
        .pc_plus4_d    (pc_plus4_d),
        .rs_val_d      (rs_val_d),
        .rt_val_d      (rt_val_d),
        .pred_taken_d  (pred_taken_d),
        .pred_target_d (pred_target_d),
        .imm_ext_d     (imm_ext_d),
        .link_pc_d     (link_pc_d),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ins, input logic [31:0] pc4,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic pt, input logic [31:0] ptg);
        instr_d       = ins;
        pc_plus4_d    = pc4;
        rs_val_d      = rs;
        rt_val_d      = rt;
        pred_taken_d  = pt;
        pred_target_d = ptg;
    endtask

    // Present one instruction for one edge, check the redirect it produces,
    // then spend an idle cycle so the next instruction is not wrong-path.
    task automatic issue_chk(input string tag, input logic [31:0] ins, input logic [31:0] pc4,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic pt, input logic [31:0] ptg,
                             input logic exp_redir, input logic [31:0] exp_pc);
        set_instr(ins, pc4, rs, rt, pt, ptg);
        valid_d = 1'b1;
        stall_d = 1'b0;
        tick();
        valid_d = 1'b0;
        check_val({tag, ".redirect"}, 32'(redirect), 32'(exp_redir));
        if (exp_redir) check_val({tag, ".redirect_pc"}, redirect_pc, exp_pc);
        tick();
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_tgt);
        pc_f = pc;
        #1;
        check_val({tag, ".pred_taken_f"}, 32'(pred_taken_f), 32'(exp_taken));
        check_val({tag, ".pred_target_f"}, pred_target_f, exp_tgt);
    endtask

    task automatic imm_chk(input string tag, input logic [31:0] ins, input logic [31:0] exp);
        instr_d = ins;
        #1;
        check_val(tag, imm_ext_d, exp);
    endtask

    initial begin
        rst = 1'b1;
        pc_f = 32'h0040_0000;
        valid_d = 1'b0;
        stall_d = 1'b0;
        set_instr(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        check_val("rst.redirect", 32'(redirect), 32'h0);
        check_val("rst.redirect_pc", redirect_pc, 32'h0);
        look("rst.lookup", 32'h0040_0000, 1'b0, 32'h0);
        rst = 1'b0;
        tick();

        // Immediate extension and link address
        imm_chk("imm.ori",  32'h3400_8000, 32'h0000_8000);
        imm_chk("imm.lui",  32'h3C00_8000, 32'h8000_0000);
        imm_chk("imm.addi", 32'h2000_8000, 32'hFFFF_8000);
        imm_chk("imm.xori", 32'h3800_FFFF, 32'h0000_FFFF);
        imm_chk("imm.andi", 32'h3000_ABCD, 32'h0000_ABCD);
        imm_chk("imm.bne",  32'h1422_FFFF, 32'hFFFF_FFFF);
        pc_plus4_d = 32'h0000_5000;
        instr_d    = 32'h0C00_0040;
        #1;
        check_val("jal.link", link_pc_d, 32'h0000_5004);

        // BEQ taken, predicted not-taken: allocate weak-taken
        issue_chk("beq", 32'h1022_0003, 32'h0040_0004, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 32'h0040_0010);
        look("beq.alloc", 32'h0040_0000, 1'b1, 32'h0040_0010);

        // BNE backward: allocate, then saturate upward, then walk down to 00 and back
        issue_chk("bne", 32'h1422_FFFF, 32'h0000_1000, 32'd1, 32'd2, 1'b0, 32'h0, 1'b1, 32'h0000_0FFC);
        look("bne.alloc", 32'h0000_0FFC, 1'b1, 32'h0000_0FFC);
        for (int i = 0; i < 3; i++) begin
            issue_chk("bne.pred_ok", 32'h1422_FFFF, 32'h0000_1000, 32'd1, 32'd2, 1'b1, 32'h0000_0FFC, 1'b0, 32'h0);
        end
        look("bne.sat_hi", 32'h0000_0FFC, 1'b1, 32'h0000_0FFC);
        issue_chk("bne.nt1", 32'h1422_FFFF, 32'h0000_1000, 32'd3, 32'd3, 1'b1, 32'h0000_0FFC, 1'b1, 32'h0000_1000);
        look("bne.ctr10", 32'h0000_0FFC, 1'b1, 32'h0000_0FFC);
        issue_chk("bne.nt2", 32'h1422_FFFF, 32'h0000_1000, 32'd3, 32'd3, 1'b1, 32'h0000_0FFC, 1'b1, 32'h0000_1000);
        look("bne.ctr01", 32'h0000_0FFC, 1'b0, 32'h0000_0FFC);
        issue_chk("bne.nt3", 32'h1422_FFFF, 32'h0000_1000, 32'd3, 32'd3, 1'b0, 32'h0, 1'b0, 32'h0);
        issue_chk("bne.nt4", 32'h1422_FFFF, 32'h0000_1000, 32'd3, 32'd3, 1'b0, 32'h0, 1'b0, 32'h0);
        issue_chk("bne.tk",  32'h1422_FFFF, 32'h0000_1000, 32'd1, 32'd2, 1'b0, 32'h0, 1'b1, 32'h0000_0FFC);
        look("bne.sat_lo", 32'h0000_0FFC, 1'b0, 32'h0000_0FFC);

        // Jumps: J allocates strong-taken, JR goes to rs
        issue_chk("j", 32'h0810_0004, 32'h9000_0004, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h9040_0010);
        look("j.alloc", 32'h9000_0000, 1'b1, 32'h9040_0010);
        issue_chk("j.alias_nt", 32'h1022_0003, 32'h9000_0004, 32'd1, 32'd2, 1'b1, 32'h9040_0010, 1'b1, 32'h9000_0004);
        look("j.ctr10", 32'h9000_0000, 1'b1, 32'h9040_0010);
        issue_chk("jr", 32'h0020_0008, 32'h0000_2000, 32'h1234_5678, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);

        // REGIMM signed conditions
        issue_chk("bgez", 32'h0421_0004, 32'h0000_3000, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        issue_chk("bltz", 32'h0420_0004, 32'h0000_3000, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_3010);
        issue_chk("regimm2", 32'h0422_0004, 32'h0000_3000, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        issue_chk("blez0", 32'h1820_0004, 32'h0000_3000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_3010);
        issue_chk("bgtz0", 32'h1C20_0004, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 32'h0000_3010, 1'b1, 32'h0000_3000);

        // Stale alias: non-control predicted taken invalidates the entry
        issue_chk("alias", 32'h3400_0001, 32'h0040_0004, 32'h0, 32'h0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0004);
        look("alias.inv", 32'h0040_0000, 1'b0, 32'h0);

        // Mispredict held under stall, then wrong-path instruction ignored
        set_instr(32'h1022_0003, 32'h0000_6004, 32'd7, 32'd7, 1'b0, 32'h0);
        valid_d = 1'b1;
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall.no_redirect", 32'(redirect), 32'h0);
        end
        stall_d = 1'b0;
        tick();
        check_val("stall.redirect", 32'(redirect), 32'h1);
        check_val("stall.redirect_pc", redirect_pc, 32'h0000_6010);
        set_instr(32'h1022_0003, 32'h0000_7004, 32'd7, 32'd7, 1'b0, 32'h0);
        tick();
        valid_d = 1'b0;
        check_val("wrongpath.redirect", 32'(redirect), 32'h0);
        look("wrongpath.no_alloc", 32'h0000_7000, 1'b0, 32'h0);
        look("stall.alloc", 32'h0000_6000, 1'b1, 32'h0000_6010);

        // Asynchronous reset while a redirect is out
        set_instr(32'h1022_0003, 32'h0000_8004, 32'd7, 32'd7, 1'b0, 32'h0);
        valid_d = 1'b1;
        tick();
        valid_d = 1'b0;
        check_val("pre_rst.redirect", 32'(redirect), 32'h1);
        #2;
        rst = 1'b1;
        pc_f = 32'h0000_6000;
        #1;
        check_val("async_rst.redirect", 32'(redirect), 32'h0);
        check_val("async_rst.redirect_pc", redirect_pc, 32'h0);
        check_val("async_rst.lookup", 32'(pred_taken_f), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        look("post_rst.a", 32'h0000_8000, 1'b0, 32'h0);
        look("post_rst.b", 32'h0000_0FFC, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
